block_average_downscale: RTL and testbench

- Frame downscaler, 320x240 to 160x120, by 2x2 block averaging.
- Reads a 320x240 8-bit source buffer through a 1-cycle-latency synchronous read port and writes a 160x120 destination buffer.
- Acts as the zoom-out counterpart of the pixel-replication upscaler on the same frame-buffer interface.
- Level-enabled: runs while enable is high and holds done until enable drops.

---
 rtl/block_average_downscale.sv | 126 ++++++++++++
 tb/tb_block_average_downscale.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/block_average_downscale.sv
// 2x2 block-averaging frame downscaler: reads a source frame over a 1-cycle-latency port, writes a half-size frame.
// Build option BLOCK_AVERAGE_ROUND_EN selects round-half-up averaging instead of truncation.
module block_average_downscale #(
  parameter int IN_WIDTH  = 320,
  parameter int IN_HEIGHT = 240,
  parameter int PIXEL_W   = 8,
  parameter int RADDR_W   = 17,
  parameter int WADDR_W   = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PIXEL_W-1:0] pixel_in,
  output logic [RADDR_W-1:0] read_addr,
  output logic [PIXEL_W-1:0] pixel_out,
  output logic [WADDR_W-1:0] write_addr,
  output logic               write_en,
  output logic               done
);
  localparam int OUT_W = IN_WIDTH / 2;
  localparam int OUT_H = IN_HEIGHT / 2;
  localparam int XW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int YW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int ACC_W = PIXEL_W + 2;

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, ACC, WR, DONE} state_t;

  state_t            state, state_n;
  logic [XW-1:0]     xo;
  logic [YW-1:0]     yo;
  logic [ACC_W-1:0]  acc, sum;
  logic [PIXEL_W-1:0] avg;
  logic              last_col, last_row;

  assign last_col = (xo == XW'(OUT_W - 1));
  assign last_row = (yo == YW'(OUT_H - 1));
  assign sum      = acc + ACC_W'(pixel_in);

`ifdef BLOCK_AVERAGE_ROUND_EN
  assign avg = PIXEL_W'((sum + ACC_W'(2)) >> 2);
`else
  assign avg = PIXEL_W'(sum >> 2);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else begin
      case (state)
        IDLE:    state_n = RD0;
        RD0:     state_n = RD1;
        RD1:     state_n = RD2;
        RD2:     state_n = RD3;
        RD3:     state_n = ACC;
        ACC:     state_n = WR;
        WR:      state_n = (last_col && last_row) ? DONE : RD0;
        DONE:    state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  // Read data trails the address by one state, so each RD state folds in the previous sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_addr  <= '0;
      write_addr <= '0;
      pixel_out  <= '0;
      write_en   <= 1'b0;
      done       <= 1'b0;
      acc        <= '0;
      xo         <= '0;
      yo         <= '0;
    end else if (!enable) begin
      read_addr  <= '0;
      write_addr <= '0;
      pixel_out  <= '0;
      write_en   <= 1'b0;
      done       <= 1'b0;
      acc        <= '0;
      xo         <= '0;
      yo         <= '0;
    end else begin
      write_en <= 1'b0;
      case (state)
        RD0: read_addr <= read_addr + RADDR_W'(1);
        RD1: begin
          read_addr <= read_addr + RADDR_W'(IN_WIDTH - 1);
          acc       <= ACC_W'(pixel_in);
        end
        RD2: begin
          read_addr <= read_addr + RADDR_W'(1);
          acc       <= sum;
        end
        RD3: acc <= sum;
        ACC: begin
          acc       <= sum;
          pixel_out <= avg;
          write_en  <= 1'b1;
        end
        WR: begin
          if (last_col && last_row) done <= 1'b1;
          else begin
            write_addr <= write_addr + WADDR_W'(1);
            // read_addr sits on the block's bottom-right pixel; step to the next block's top-left
            if (last_col) begin
              xo        <= '0;
              yo        <= yo + YW'(1);
              read_addr <= read_addr + RADDR_W'(1);
            end else begin
              xo        <= xo + XW'(1);
              read_addr <= read_addr - RADDR_W'(IN_WIDTH - 1);
            end
          end
        end
        DONE:    done <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_block_average_downscale.sv
// Scoreboard bench for block_average_downscale on a 320x8 source (160x4 output).
module tb_block_average_downscale;
  localparam int W    = 320;
  localparam int H    = 8;
  localparam int NOUT = (W / 2) * (H / 2);
  localparam int FRAME_EDGES = 1 + 6 * NOUT;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  pixel_in;
  logic [16:0] read_addr;
  logic [7:0]  pixel_out;
  logic [14:0] write_addr;
  logic        write_en, done;

  int tests = 0;
  int fails = 0;
  int wr_cnt = 0;

  logic [7:0] src [0:W*H-1];

  typedef struct packed {
    logic [14:0] addr;
    logic [7:0]  pix;
  } exp_t;
  exp_t sb[$];

  block_average_downscale #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel_in(pixel_in),
    .read_addr(read_addr), .pixel_out(pixel_out), .write_addr(write_addr),
    .write_en(write_en), .done(done)
  );

  always #5 clk = ~clk;

  // source buffer: synchronous read, one cycle of latency
  always @(posedge clk) pixel_in <= src[read_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // hand-computed block averages for the directed source image
  function automatic logic [7:0] exp_pix(input int k);
    case (k)
`ifdef BLOCK_AVERAGE_ROUND_EN
      0:       return 8'd12;   // 10+11+12+13=46 -> (48)>>2
      2:       return 8'd2;    // 1+2+2+2=7 -> (9)>>2
`else
      0:       return 8'd11;   // 46>>2
      2:       return 8'd1;    // 7>>2
`endif
      161:     return 8'd255;  // 1020 -> 255 either way
      default: return 8'd100;
    endcase
  endfunction

  task automatic push(input int n);
    for (int k = 0; k < n; k++) sb.push_back({15'(k), exp_pix(k)});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_raddr"}, 32'(read_addr), 0);
    check({tag, "_waddr"}, 32'(write_addr), 0);
    check({tag, "_wen"}, 32'(write_en), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      exp_t e;
      wr_cnt++;
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d pix %0d, expected no write", write_addr, pixel_out);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(write_addr), 32'(e.addr));
        check("wr_pix", 32'(pixel_out), 32'(e.pix));
      end
    end
  end

  initial begin
    for (int i = 0; i < W*H; i++) src[i] = 8'd100;
    src[0] = 8'd10;  src[1] = 8'd11;  src[320] = 8'd12; src[321] = 8'd13;
    src[4] = 8'd1;   src[5] = 8'd2;   src[324] = 8'd2;  src[325] = 8'd2;
    src[642] = 8'd255; src[643] = 8'd255; src[962] = 8'd255; src[963] = 8'd255;

    reset = 1'b1;
    enable = 1'b0;
    #12;
    check_zero("reset");
    check("reset_pix", 32'(pixel_out), 0);
    @(negedge clk) reset = 1'b0;

    // full frame, then hold in DONE
    push(NOUT);
    @(negedge clk) enable = 1'b1;
    for (int c = 1; c <= FRAME_EDGES + 1000; c++) begin
      @(posedge clk); #1;
      if (c == 1)    check("first_raddr", 32'(read_addr), 0);
      if (c == 2)    check("second_raddr", 32'(read_addr), 1);
      if (c == 967)  check("blk161_rd0", 32'(read_addr), 642);
      if (c == 968)  check("blk161_rd1", 32'(read_addr), 643);
      if (c == 969)  check("blk161_rd2", 32'(read_addr), 962);
      if (c == 970)  check("blk161_rd3", 32'(read_addr), 963);
      if (c == FRAME_EDGES - 1) check("done_early", 32'(done), 0);
      if (c == FRAME_EDGES)     check("done_rise", 32'(done), 1);
      if (c == FRAME_EDGES + 1000) check("done_hold", 32'(done), 1);
    end
    check("frame_writes", 32'(wr_cnt), 32'(NOUT));
    check("frame_sb_empty", 32'(sb.size()), 0);
    @(negedge clk) enable = 1'b0;
    @(posedge clk); #1;
    check_zero("done_drop");

    // abort in RD2 of output 500 (x=20, y=3)
    wr_cnt = 0;
    push(500);
    @(negedge clk) enable = 1'b1;
    for (int c = 1; c <= 3003; c++) begin
      @(posedge clk); #1;
    end
    check("abort_rd2_addr", 32'(read_addr), 2280);
    enable = 1'b0;
    @(posedge clk); #1;
    check_zero("abort");
    repeat (10) @(posedge clk);
    #1;
    check("abort_writes", 32'(wr_cnt), 500);
    check("abort_sb_empty", 32'(sb.size()), 0);

    // restart from pixel 0, then async reset between edges
    wr_cnt = 0;
    push(3);
    @(negedge clk) enable = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("restart_raddr0", 32'(read_addr), 0);
      if (c == 2) check("restart_raddr1", 32'(read_addr), 1);
    end
    #2 reset = 1'b1;
    #1;
    check_zero("async_reset");
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_rd0", 32'(read_addr), 0);
    @(posedge clk); #1;
    check("post_reset_rd1", 32'(read_addr), 1);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("restart_writes", 32'(wr_cnt), 3);
    check("restart_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
